// File: rtl/cp0_exc_ctrl_if.sv
// CP0 exception controller bus: MEM-stage event inputs, live CP0 register
// views, the WB MTC0 request, the shared CP0 write port, the cause strobe and
// pipeline stall/flush/redirect. 'slave' is the controller side, 'master' the pipeline/CP0 side.
interface cp0_exc_ctrl_if;
    logic        mem_valid_i;
    logic [31:0] mem_pc_i;
    logic        mem_bd_i;
    logic        exc_req_i;
    logic [4:0]  exc_code_i;
    logic        eret_i;
    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic [31:0] epc_i;
    logic        mtc0_we_i;
    logic [4:0]  mtc0_waddr_i;
    logic [31:0] mtc0_data_i;
    logic        cp0_we_o;
    logic [4:0]  cp0_waddr_o;
    logic [31:0] cp0_data_o;
    logic        exc_cause_we_o;
    logic [4:0]  exc_code_o;
    logic        exc_bd_o;
    logic        stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;

    modport slave (
        input  mem_valid_i, mem_pc_i, mem_bd_i, exc_req_i, exc_code_i, eret_i,
               status_i, cause_i, epc_i, mtc0_we_i, mtc0_waddr_i, mtc0_data_i,
        output cp0_we_o, cp0_waddr_o, cp0_data_o, exc_cause_we_o, exc_code_o,
               exc_bd_o, stall_o, flush_o, new_pc_o
    );

    modport master (
        output mem_valid_i, mem_pc_i, mem_bd_i, exc_req_i, exc_code_i, eret_i,
               status_i, cause_i, epc_i, mtc0_we_i, mtc0_waddr_i, mtc0_data_i,
        input  cp0_we_o, cp0_waddr_o, cp0_data_o, exc_cause_we_o, exc_code_o,
               exc_bd_o, stall_o, flush_o, new_pc_o
    );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// Exception/interrupt/ERET sequencer owning the single CP0 write port (shared with WB MTC0).
// Latency: exception/interrupt flush at cycle 4 (back in IDLE at 5); ERET flush at cycle 3 (IDLE at 4).
// Backpressure: stall_o holds the pipeline for the whole sequence; events seen outside IDLE are dropped.
// Ports: clk, rst (async, active-high), bus (cp0_exc_ctrl_if.slave) carrying MEM events,
// live Status/Cause/EPC, MTC0 request, CP0 write port, cause strobe, stall/flush/new_pc.
module cp0_exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
    parameter logic [4:0]  ADDR_STATUS = 5'd12,
    parameter logic [4:0]  ADDR_CAUSE  = 5'd13,
    parameter logic [4:0]  ADDR_EPC    = 5'd14
) (
    input  logic              clk,
    input  logic              rst,
    cp0_exc_ctrl_if.slave     bus
);
    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        WR_EPC,
        WR_STATUS,
        REDIRECT
    } state_t;

    state_t      state;
    logic [4:0]  code_q;
    logic        bd_q;
    logic        eret_q;
    logic [31:0] epc_val_q;

    logic int_pending;
    logic accept;

    // Interrupts need a pending+enabled line, IE set and no exception already in progress (EXL clear).
    assign int_pending = (|(bus.cause_i[15:8] & bus.status_i[15:8]))
                         & bus.status_i[0] & ~bus.status_i[1];

    assign accept = bus.mem_valid_i & (int_pending | bus.exc_req_i | bus.eret_i);

    // Cause is only touched through the dedicated strobe, so most of it and its address go unused here.
    logic unused_ok;
    assign unused_ok = ^{bus.cause_i[31:16], bus.cause_i[7:0], ADDR_CAUSE};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            code_q    <= 5'd0;
            bd_q      <= 1'b0;
            eret_q    <= 1'b0;
            epc_val_q <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= DRAIN;
                        bd_q      <= bus.mem_bd_i;
                        // A delay-slot victim restarts at its branch.
                        epc_val_q <= bus.mem_bd_i ? (bus.mem_pc_i - 32'd4) : bus.mem_pc_i;
                        if (int_pending) begin
                            code_q <= 5'd0;
                            eret_q <= 1'b0;
                        end else if (bus.exc_req_i) begin
                            code_q <= bus.exc_code_i;
                            eret_q <= 1'b0;
                        end else begin
                            code_q <= 5'd0;
                            eret_q <= 1'b1;
                        end
                    end
                end
                DRAIN:     state <= eret_q ? WR_STATUS : WR_EPC;
                WR_EPC:    state <= WR_STATUS;
                WR_STATUS: state <= REDIRECT;
                REDIRECT:  state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    // Output decode from registered state; the port is handed to MTC0 only while nothing is in flight
    // or while the last older MTC0 drains.
    always_comb begin
        bus.cp0_we_o       = 1'b0;
        bus.cp0_waddr_o    = 5'd0;
        bus.cp0_data_o     = 32'd0;
        bus.exc_cause_we_o = 1'b0;
        bus.exc_code_o     = 5'd0;
        bus.exc_bd_o       = 1'b0;
        bus.flush_o        = 1'b0;
        bus.new_pc_o       = 32'd0;
        case (state)
            IDLE, DRAIN: begin
                bus.cp0_we_o    = bus.mtc0_we_i;
                bus.cp0_waddr_o = bus.mtc0_waddr_i;
                bus.cp0_data_o  = bus.mtc0_data_i;
            end
            WR_EPC: begin
                bus.cp0_we_o       = 1'b1;
                bus.cp0_waddr_o    = ADDR_EPC;
                bus.cp0_data_o     = epc_val_q;
                bus.exc_cause_we_o = 1'b1;
                bus.exc_code_o     = code_q;
                bus.exc_bd_o       = bd_q;
            end
            WR_STATUS: begin
                // Status read live so an MTC0 completed during DRAIN is preserved.
                bus.cp0_we_o    = 1'b1;
                bus.cp0_waddr_o = ADDR_STATUS;
                bus.cp0_data_o  = eret_q ? (bus.status_i & ~32'h2) : (bus.status_i | 32'h2);
            end
            REDIRECT: begin
                bus.flush_o  = 1'b1;
                // EPC sampled here so a drained MTC0 to EPC takes effect on ERET.
                bus.new_pc_o = eret_q ? bus.epc_i : EXC_VECTOR;
            end
            default: ;
        endcase
    end

    assign bus.stall_o = (state != IDLE);
endmodule

// File: tb/tb_cp0_exc_ctrl.sv
module tb_cp0_exc_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    cp0_exc_ctrl_if bus();

    cp0_exc_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.mem_valid_i  = 1'b0;
        bus.mem_pc_i     = 32'd0;
        bus.mem_bd_i     = 1'b0;
        bus.exc_req_i    = 1'b0;
        bus.exc_code_i   = 5'd0;
        bus.eret_i       = 1'b0;
        bus.mtc0_we_i    = 1'b0;
        bus.mtc0_waddr_i = 5'd0;
        bus.mtc0_data_i  = 32'd0;
    endtask

    task automatic test_reset;
        clear_inputs();
        bus.status_i = 32'h0; bus.cause_i = 32'h0; bus.epc_i = 32'h0;
        rst = 1'b1;
        bus.mtc0_we_i = 1'b1; bus.mtc0_waddr_i = 5'd9; bus.mtc0_data_i = 32'h1234_5678;
        #2;
        checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", bus.stall_o); end
        checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL rst_flush: got %b want 0", bus.flush_o); end
        checks++; if (bus.exc_cause_we_o !== 1'b0 || bus.exc_code_o !== 5'd0 || bus.exc_bd_o !== 1'b0)
            begin errors++; $display("FAIL rst_cause: got we=%b code=%h bd=%b want 0/0/0", bus.exc_cause_we_o, bus.exc_code_o, bus.exc_bd_o); end
        checks++; if (bus.new_pc_o !== 32'd0) begin errors++; $display("FAIL rst_new_pc: got %h want 0", bus.new_pc_o); end
        checks++; if (bus.cp0_we_o !== 1'b1 || bus.cp0_waddr_o !== 5'd9 || bus.cp0_data_o !== 32'h1234_5678)
            begin errors++; $display("FAIL rst_passthru: got we=%b a=%0d d=%h want 1/9/12345678", bus.cp0_we_o, bus.cp0_waddr_o, bus.cp0_data_o); end
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
    endtask

    // Exception with no MTC0 activity; checks every cycle of the sequence.
    task automatic test_exception;
        step();
        bus.status_i = 32'h1000_0001; bus.cause_i = 32'h0;
        bus.mem_valid_i = 1'b1; bus.exc_req_i = 1'b1; bus.exc_code_i = 5'h0C;
        bus.mem_pc_i = 32'h0000_0100; bus.mem_bd_i = 1'b0;
        #1;
        checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL exc_c0_stall: got %b want 0", bus.stall_o); end
        step(); clear_inputs(); #1;
        checks++; if (bus.stall_o !== 1'b1 || bus.cp0_we_o !== 1'b0 || bus.flush_o !== 1'b0)
            begin errors++; $display("FAIL exc_c1: got stall=%b we=%b flush=%b want 1/0/0", bus.stall_o, bus.cp0_we_o, bus.flush_o); end
        step(); #1;
        checks++; if (bus.cp0_we_o !== 1'b1 || bus.cp0_waddr_o !== 5'd14 || bus.cp0_data_o !== 32'h0000_0100)
            begin errors++; $display("FAIL exc_c2_epc: got we=%b a=%0d d=%h want 1/14/00000100", bus.cp0_we_o, bus.cp0_waddr_o, bus.cp0_data_o); end
        checks++; if (bus.exc_cause_we_o !== 1'b1 || bus.exc_code_o !== 5'h0C || bus.exc_bd_o !== 1'b0)
            begin errors++; $display("FAIL exc_c2_cause: got we=%b code=%h bd=%b want 1/0c/0", bus.exc_cause_we_o, bus.exc_code_o, bus.exc_bd_o); end
        step(); #1;
        checks++; if (bus.cp0_we_o !== 1'b1 || bus.cp0_waddr_o !== 5'd12 || bus.cp0_data_o !== 32'h1000_0003 || bus.exc_cause_we_o !== 1'b0)
            begin errors++; $display("FAIL exc_c3_status: got we=%b a=%0d d=%h cwe=%b want 1/12/10000003/0", bus.cp0_we_o, bus.cp0_waddr_o, bus.cp0_data_o, bus.exc_cause_we_o); end
        step(); #1;
        checks++; if (bus.flush_o !== 1'b1 || bus.new_pc_o !== 32'h0000_0020 || bus.cp0_we_o !== 1'b0 || bus.stall_o !== 1'b1)
            begin errors++; $display("FAIL exc_c4_redirect: got flush=%b pc=%h we=%b stall=%b want 1/00000020/0/1", bus.flush_o, bus.new_pc_o, bus.cp0_we_o, bus.stall_o); end
        step(); #1;
        checks++; if (bus.stall_o !== 1'b0 || bus.flush_o !== 1'b0)
            begin errors++; $display("FAIL exc_c5_idle: got stall=%b flush=%b want 0/0", bus.stall_o, bus.flush_o); end
    endtask

    task automatic test_delay_slot;
        step();
        bus.status_i = 32'h1000_0001;
        bus.mem_valid_i = 1'b1; bus.exc_req_i = 1'b1; bus.exc_code_i = 5'h04;
        bus.mem_pc_i = 32'h0000_0000; bus.mem_bd_i = 1'b1;
        step(); clear_inputs();
        step(); #1;
        checks++; if (bus.cp0_data_o !== 32'hFFFF_FFFC || bus.cp0_waddr_o !== 5'd14 || bus.exc_bd_o !== 1'b1 || bus.exc_code_o !== 5'h04)
            begin errors++; $display("FAIL bd_epc: got a=%0d d=%h bd=%b code=%h want 14/fffffffc/1/04", bus.cp0_waddr_o, bus.cp0_data_o, bus.exc_bd_o, bus.exc_code_o); end
        step(); step(); step();
    endtask

    task automatic test_int_priority;
        // Interrupt enabled and pending: beats both exception and ERET.
        step();
        bus.cause_i = 32'h0000_8000; bus.status_i = 32'h1000_8001;
        bus.mem_valid_i = 1'b1; bus.exc_req_i = 1'b1; bus.exc_code_i = 5'h0C; bus.eret_i = 1'b1;
        bus.mem_pc_i = 32'h0000_0200;
        step(); clear_inputs();
        step(); #1;
        checks++; if (bus.exc_cause_we_o !== 1'b1 || bus.exc_code_o !== 5'd0 || bus.cp0_data_o !== 32'h0000_0200)
            begin errors++; $display("FAIL int_code: got cwe=%b code=%h epc=%h want 1/00/00000200", bus.exc_cause_we_o, bus.exc_code_o, bus.cp0_data_o); end
        step(); #1;
        checks++; if (bus.cp0_data_o !== 32'h1000_8003) begin errors++; $display("FAIL int_status: got %h want 10008003", bus.cp0_data_o); end
        step(); step();
        // EXL set masks the interrupt; the exception is taken.
        bus.status_i = 32'h1000_8003;
        bus.mem_valid_i = 1'b1; bus.exc_req_i = 1'b1; bus.exc_code_i = 5'h0C; bus.eret_i = 1'b1;
        step(); clear_inputs();
        step(); #1;
        checks++; if (bus.exc_cause_we_o !== 1'b1 || bus.exc_code_o !== 5'h0C)
            begin errors++; $display("FAIL int_masked_exc: got cwe=%b code=%h want 1/0c", bus.exc_cause_we_o, bus.exc_code_o); end
        step(); step(); step();
        bus.cause_i = 32'h0;
    endtask

    task automatic test_eret;
        step();
        bus.status_i = 32'h1000_0003; bus.epc_i = 32'h0000_0100;
        bus.mem_valid_i = 1'b1; bus.eret_i = 1'b1;
        step(); clear_inputs();
        // DRAIN: older MTC0 to EPC completes through the port.
        bus.mtc0_we_i = 1'b1; bus.mtc0_waddr_i = 5'd14; bus.mtc0_data_i = 32'h0000_0400;
        #1;
        checks++; if (bus.cp0_we_o !== 1'b1 || bus.cp0_waddr_o !== 5'd14 || bus.cp0_data_o !== 32'h0000_0400 || bus.stall_o !== 1'b1)
            begin errors++; $display("FAIL eret_drain: got we=%b a=%0d d=%h stall=%b want 1/14/00000400/1", bus.cp0_we_o, bus.cp0_waddr_o, bus.cp0_data_o, bus.stall_o); end
        step(); clear_inputs(); bus.epc_i = 32'h0000_0400; #1;
        checks++; if (bus.cp0_we_o !== 1'b1 || bus.cp0_waddr_o !== 5'd12 || bus.cp0_data_o !== 32'h1000_0001 || bus.exc_cause_we_o !== 1'b0)
            begin errors++; $display("FAIL eret_status: got we=%b a=%0d d=%h cwe=%b want 1/12/10000001/0", bus.cp0_we_o, bus.cp0_waddr_o, bus.cp0_data_o, bus.exc_cause_we_o); end
        step(); #1;
        checks++; if (bus.flush_o !== 1'b1 || bus.new_pc_o !== 32'h0000_0400)
            begin errors++; $display("FAIL eret_redirect: got flush=%b pc=%h want 1/00000400", bus.flush_o, bus.new_pc_o); end
        step(); #1;
        checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL eret_idle: got stall=%b want 0", bus.stall_o); end
    endtask

    task automatic test_mtc0_passthrough;
        step();
        bus.status_i = 32'h1000_0001;
        bus.mtc0_we_i = 1'b1; bus.mtc0_waddr_i = 5'd11; bus.mtc0_data_i = 32'hDEAD_BEEF;
        // Exception request without mem_valid must be ignored.
        bus.exc_req_i = 1'b1; bus.exc_code_i = 5'h08;
        #1;
        checks++; if (bus.cp0_we_o !== 1'b1 || bus.cp0_waddr_o !== 5'd11 || bus.cp0_data_o !== 32'hDEAD_BEEF)
            begin errors++; $display("FAIL mtc0_idle: got we=%b a=%0d d=%h want 1/11/deadbeef", bus.cp0_we_o, bus.cp0_waddr_o, bus.cp0_data_o); end
        step(); clear_inputs(); #1;
        checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL novalid_ignored: got stall=%b want 0", bus.stall_o); end
        bus.mem_valid_i = 1'b1; bus.exc_req_i = 1'b1; bus.exc_code_i = 5'h08; bus.mem_pc_i = 32'h0000_0300;
        step(); clear_inputs();
        bus.mtc0_we_i = 1'b1; bus.mtc0_waddr_i = 5'd12; bus.mtc0_data_i = 32'h1000_FF01;
        step(); clear_inputs(); bus.status_i = 32'h1000_FF01;
        // Stray MTC0 in WR_EPC must not reach the port.
        bus.mtc0_we_i = 1'b1; bus.mtc0_waddr_i = 5'd9; bus.mtc0_data_i = 32'h5555_5555;
        #1;
        checks++; if (bus.cp0_waddr_o !== 5'd14 || bus.cp0_data_o !== 32'h0000_0300)
            begin errors++; $display("FAIL mtc0_ignored_wr_epc: got a=%0d d=%h want 14/00000300", bus.cp0_waddr_o, bus.cp0_data_o); end
        step(); clear_inputs(); #1;
        checks++; if (bus.cp0_waddr_o !== 5'd12 || bus.cp0_data_o !== 32'h1000_FF03)
            begin errors++; $display("FAIL mtc0_status_kept: got a=%0d d=%h want 12/1000ff03", bus.cp0_waddr_o, bus.cp0_data_o); end
        step(); step();
    endtask

    task automatic test_back_to_back;
        step();
        bus.status_i = 32'h1000_0001;
        bus.mem_valid_i = 1'b1; bus.exc_req_i = 1'b1; bus.exc_code_i = 5'h0C; bus.mem_pc_i = 32'h0000_0500;
        step(); bus.exc_code_i = 5'h05; bus.mem_pc_i = 32'h0000_0600;
        step(); #1;
        checks++; if (bus.exc_code_o !== 5'h0C || bus.cp0_data_o !== 32'h0000_0500)
            begin errors++; $display("FAIL b2b_first: got code=%h epc=%h want 0c/00000500", bus.exc_code_o, bus.cp0_data_o); end
        step(); step(); step(); #1;
        checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL b2b_idle_c5: got stall=%b want 0", bus.stall_o); end
        step(); clear_inputs(); #1;
        checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL b2b_second_accept: got stall=%b want 1", bus.stall_o); end
        step(); #1;
        checks++; if (bus.exc_cause_we_o !== 1'b1 || bus.exc_code_o !== 5'h05 || bus.cp0_data_o !== 32'h0000_0600)
            begin errors++; $display("FAIL b2b_second: got cwe=%b code=%h epc=%h want 1/05/00000600", bus.exc_cause_we_o, bus.exc_code_o, bus.cp0_data_o); end
        step(); step(); step();
    endtask

    task automatic test_reset_mid;
        step();
        bus.status_i = 32'h1000_0001;
        bus.mem_valid_i = 1'b1; bus.exc_req_i = 1'b1; bus.exc_code_i = 5'h0C; bus.mem_pc_i = 32'h0000_0700;
        step(); clear_inputs();
        step(); #1;
        checks++; if (bus.exc_cause_we_o !== 1'b1) begin errors++; $display("FAIL rstmid_in_wr_epc: got cwe=%b want 1", bus.exc_cause_we_o); end
        #1 rst = 1'b1;
        #1;
        checks++; if (bus.stall_o !== 1'b0 || bus.flush_o !== 1'b0 || bus.cp0_we_o !== 1'b0 || bus.exc_cause_we_o !== 1'b0)
            begin errors++; $display("FAIL rstmid_immediate: got stall=%b flush=%b we=%b cwe=%b want 0/0/0/0", bus.stall_o, bus.flush_o, bus.cp0_we_o, bus.exc_cause_we_o); end
        @(negedge clk); rst = 1'b0;
        step(); #1;
        checks++; if (bus.cp0_we_o !== 1'b0 || bus.stall_o !== 1'b0) begin errors++; $display("FAIL rstmid_no_status: got we=%b stall=%b want 0/0", bus.cp0_we_o, bus.stall_o); end
        step(); #1;
        checks++; if (bus.flush_o !== 1'b0 || bus.cp0_we_o !== 1'b0) begin errors++; $display("FAIL rstmid_no_flush: got flush=%b we=%b want 0/0", bus.flush_o, bus.cp0_we_o); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_exception();
        test_delay_slot();
        test_int_priority();
        test_eret();
        test_mtc0_passthrough();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
